// File: rtl/booth_mul_arbiter_if.sv
// Bundle of requester, multiplier and response signals around the shared Booth multiplier.
interface booth_mul_arbiter_if #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  mul_ld;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_ab;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_ab;
  logic                  rsp_ready;
  logic                  busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_ab, rsp_ready,
    output req_ready, mul_ld, mul_a, mul_b, rsp_valid, rsp_id, rsp_ab, busy
  );

  // Requesters, multiplier and response consumer side.
  modport master (
    output req_valid, req_a, req_b, mul_done, mul_ab, rsp_ready,
    input  req_ready, mul_ld, mul_a, mul_b, rsp_valid, rsp_id, rsp_ab, busy
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one variable-latency Booth multiplier between NREQ requesters.
// One job in flight at a time; the product is returned tagged with the owner's index.
module booth_mul_arbiter #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned NREQ  = 4
) (
  input logic                clk,
  input logic                reset,
  booth_mul_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0]   rsp_ab_q, rsp_ab_d;

  logic                 grant_vld;
  logic [IDW-1:0]       grant_idx;
  logic [NREQ-1:0]      grant_oh;

  // Round-robin pick: first valid requester starting just after the last grant.
  always_comb begin
    logic [IDW-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last_q) + k) % NREQ);
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign grant_oh = grant_vld ? (NREQ'(1) << grant_idx) : '0;

  // Next-state and datapath capture for the IDLE/LOAD/WAIT/RESP job sequence.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    rsp_id_d = rsp_id_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    rsp_ab_d = rsp_ab_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          mul_a_d  = bus.req_a[grant_idx*WIDTH +: WIDTH];
          mul_b_d  = bus.req_b[grant_idx*WIDTH +: WIDTH];
          rsp_id_d = grant_idx;
          last_d   = grant_idx;
          state_d  = StLoad;
        end
      end
      // mul_done may still be high from the previous job here, so it is not looked at.
      StLoad: state_d = StWait;
      StWait: begin
        if (bus.mul_done) begin
          rsp_ab_d = bus.mul_ab;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset also restarts the round-robin at requester 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= IDW'(NREQ - 1);
      rsp_id_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      rsp_ab_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rsp_id_q <= rsp_id_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      rsp_ab_q <= rsp_ab_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle) ? grant_oh : '0;
  assign bus.mul_ld    = (state_q == StLoad);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.busy      = (state_q != StIdle);
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_ab    = rsp_ab_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural variable-latency multiplier.
module tb_booth_mul_arbiter;
  localparam int unsigned W   = 128;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned PW  = 2 * W;

  typedef struct {
    logic [IDW-1:0] id;
    logic [PW-1:0]  ab;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  booth_mul_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  booth_mul_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rsp    = 0;
  exp_t exp_q[$];

  // Multiplier model controls.
  int   lat_force    = 0;
  bit   spurious_req = 1'b0;
  bit   done_on_load = 1'b0;
  bit   rand_spur    = 1'b0;
  // Requester controls.
  bit   hold_all     = 1'b0;
  bit   rand_mode    = 1'b0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Mathematical signed product of two W-bit operands.
  function automatic logic [PW-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [PW-1:0] ea, eb;
    ea = {{W{a[W-1]}}, a};
    eb = {{W{b[W-1]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [PW-1:0] garbage();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(7, 0))
      0:       return {1'b1, {(W-1){1'b0}}};
      1:       return '1;
      2:       return '0;
      3:       return W'(1);
      default: return {$urandom, $urandom, $urandom, $urandom};
    endcase
  endfunction

  // Behavioural multiplier: latches on mul_ld, answers after a random latency.
  logic [W-1:0] ma, mb;
  int           cnt      = 0;
  bit           resp_due = 1'b0;
  initial begin
    bus.mul_done = 1'b0;
    bus.mul_ab   = '0;
    forever begin
      @(negedge clk);
      bus.mul_done = 1'b0;
      if (reset) begin
        cnt      = 0;
        resp_due = 1'b0;
      end else begin
        if (resp_due) begin
          chk_bit("rsp_after_done", bus.rsp_valid, 1'b1);
          resp_due = 1'b0;
        end
        if (bus.mul_ld) begin
          chk_bit("no_ld_inflight", cnt != 0, 1'b0);
          ma  = bus.mul_a;
          mb  = bus.mul_b;
          cnt = (lat_force != 0) ? lat_force : int'($urandom_range(4, 1));
          if (done_on_load) begin
            bus.mul_done = 1'b1;
            bus.mul_ab   = garbage();
            done_on_load = 1'b0;
          end
        end else if (cnt > 0) begin
          chk("mul_a_held", PW'(bus.mul_a), PW'(ma));
          chk("mul_b_held", PW'(bus.mul_b), PW'(mb));
          cnt--;
          if (cnt == 0) begin
            bus.mul_done = 1'b1;
            bus.mul_ab   = smul(ma, mb);
            resp_due     = 1'b1;
          end
        end else if (spurious_req || (rand_spur && $urandom_range(7, 0) == 0)) begin
          bus.mul_done = 1'b1;
          bus.mul_ab   = garbage();
          spurious_req = 1'b0;
        end
      end
    end
  end

  // Reference model: round-robin grant prediction; pushes expected responses.
  int             m_last = N - 1;
  bit             m_idle = 1'b1;
  bit             ld_exp = 1'b0;
  int             g;
  logic [N-1:0]   exp_rdy;
  exp_t           e_push;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_last = N - 1;
        m_idle = 1'b1;
        ld_exp = 1'b0;
        exp_q.delete();
      end else begin
        if (ld_exp || bus.mul_ld) chk_bit("mul_ld_pulse", bus.mul_ld, ld_exp);
        ld_exp = 1'b0;
        chk_bit("busy", bus.busy, !m_idle);
        if (m_idle) begin
          g = -1;
          for (int k = 1; k <= N; k++) begin
            if (g < 0 && bus.req_valid[IDW'((m_last + k) % N)]) g = (m_last + k) % N;
          end
          exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
          chk("req_ready", PW'(bus.req_ready), PW'(exp_rdy));
          if (g >= 0) begin
            e_push.id = IDW'(g);
            e_push.ab = smul(bus.req_a[g*W +: W], bus.req_b[g*W +: W]);
            exp_q.push_back(e_push);
            m_last = g;
            m_idle = 1'b0;
            ld_exp = 1'b1;
          end
        end else begin
          chk("req_ready_busy", PW'(bus.req_ready), '0);
          if (bus.rsp_valid && bus.rsp_ready) m_idle = 1'b1;
        end
      end
    end
  end

  // Response monitor: pops expectations on handshake, checks stability under backpressure.
  bit             held = 1'b0;
  logic [IDW-1:0] h_id;
  logic [PW-1:0]  h_ab;
  exp_t           e_pop;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else if (bus.rsp_valid) begin
        if (held) begin
          chk("hold_id", PW'(bus.rsp_id), PW'(h_id));
          chk("hold_ab", bus.rsp_ab, h_ab);
        end
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_rsp");
          end else begin
            e_pop = exp_q.pop_front();
            chk("rsp_id", PW'(bus.rsp_id), PW'(e_pop.id));
            chk("rsp_ab", bus.rsp_ab, e_pop.ab);
          end
          n_rsp++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          h_id = bus.rsp_id;
          h_ab = bus.rsp_ab;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // One clock: requesters drop valid once accepted; inputs change 1 time unit after the edge.
  task automatic cyc();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    if (!hold_all) bus.req_valid = bus.req_valid & ~acc;
    if (rand_mode) begin
      bus.rsp_ready = ($urandom_range(3, 0) != 0);
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[IDW'(i)]) begin
          if ($urandom_range(2, 0) == 0) begin
            bus.req_a[i*W +: W]     = rnd_op();
            bus.req_b[i*W +: W]     = rnd_op();
            bus.req_valid[IDW'(i)]  = 1'b1;
          end
        end else if ($urandom_range(15, 0) == 0) begin
          bus.req_valid[IDW'(i)] = 1'b0;
        end
      end
    end
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_req_ready"}, PW'(bus.req_ready), '0);
    chk_bit({tag, "_mul_ld"}, bus.mul_ld, 1'b0);
    chk_bit({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk_bit({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_mul_a"}, PW'(bus.mul_a), '0);
    chk({tag, "_mul_b"}, PW'(bus.mul_b), '0);
    chk({tag, "_rsp_id"}, PW'(bus.rsp_id), '0);
    chk({tag, "_rsp_ab"}, bus.rsp_ab, '0);
    bus.req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) fail_now({tag, "_rsp_timeout"});
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) fail_now({tag, "_idle_timeout"});
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  logic [W-1:0] ta, tb;
  int           ord [5] = '{0, 1, 2, 3, 0};
  int           start;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #1;
    apply_reset("rst");

    // Single request from requester 2: 7 * -3.
    set_op(2, W'(7), ~W'(2));
    bus.req_valid = 4'b0100;
    #1;
    chk("t1_req_ready", PW'(bus.req_ready), PW'(4'b0100));
    cyc();
    chk_bit("t1_mul_ld_load", bus.mul_ld, 1'b1);
    cyc();
    chk_bit("t1_mul_ld_wait", bus.mul_ld, 1'b0);
    wait_rsp("t1");
    chk("t1_rsp_id", PW'(bus.rsp_id), PW'(2));
    chk("t1_rsp_ab", bus.rsp_ab, ~PW'(20));
    cyc();
    chk_bit("t1_idle", bus.busy, 1'b0);

    // All requesters held valid: strict round-robin from requester 0.
    apply_reset("t2rst");
    for (int i = 0; i < N; i++) set_op(i, W'(i + 1), W'(10));
    hold_all      = 1'b1;
    bus.req_valid = '1;
    for (int j = 0; j < 5; j++) begin
      wait_rsp("t2");
      chk("t2_order_id", PW'(bus.rsp_id), PW'(ord[j]));
      chk("t2_order_ab", bus.rsp_ab, PW'((ord[j] + 1) * 10));
      cyc();
    end
    hold_all      = 1'b0;
    bus.req_valid = '0;
    wait_idle("t2");

    // Backpressure for 20 cycles while another requester waits.
    bus.rsp_ready = 1'b0;
    set_op(1, ~W'(4), W'(9));
    bus.req_valid = 4'b0010;
    wait_rsp("t3");
    set_op(3, W'(3), W'(3));
    bus.req_valid[3] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      cyc();
      chk_bit("t3_rsp_valid", bus.rsp_valid, 1'b1);
      chk("t3_rsp_ab", bus.rsp_ab, ~PW'(44));
      chk("t3_req_ready", PW'(bus.req_ready), '0);
      chk_bit("t3_mul_ld", bus.mul_ld, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    cyc();
    chk_bit("t3_idle_after", bus.busy, 1'b0);
    chk("t3_next_grant", PW'(bus.req_ready), PW'(4'b1000));
    wait_rsp("t3b");
    chk("t3b_rsp_ab", bus.rsp_ab, PW'(9));
    cyc();
    wait_idle("t3");

    // Spurious done in IDLE, then in the LOAD cycle.
    spurious_req = 1'b1;
    cyc();
    cyc();
    chk_bit("t4_idle_busy", bus.busy, 1'b0);
    chk_bit("t4_idle_rsp", bus.rsp_valid, 1'b0);
    ta = rnd_op();
    tb = rnd_op();
    set_op(0, ta, tb);
    done_on_load  = 1'b1;
    lat_force     = 3;
    bus.req_valid = 4'b0001;
    wait_rsp("t4");
    chk("t4_rsp_ab", bus.rsp_ab, smul(ta, tb));
    cyc();
    lat_force = 0;
    wait_idle("t4");

    // Reset asserted while waiting for the multiplier.
    lat_force = 8;
    set_op(3, W'(5), W'(6));
    bus.req_valid = 4'b1000;
    for (int t = 0; t < 20 && !bus.mul_ld; t++) cyc();
    chk_bit("t5_saw_ld", bus.mul_ld, 1'b1);
    cyc();
    cyc();
    #2;
    apply_reset("t5rst");
    lat_force = 0;
    set_op(0, W'(11), ~W'(0));
    set_op(2, W'(12), W'(2));
    bus.req_valid = 4'b0101;
    #1;
    chk("t5_grant0", PW'(bus.req_ready), PW'(4'b0001));
    wait_rsp("t5");
    chk("t5_rsp_id", PW'(bus.rsp_id), PW'(0));
    chk("t5_rsp_ab", bus.rsp_ab, ~PW'(10));
    cyc();
    wait_rsp("t5b");
    chk("t5b_rsp_id", PW'(bus.rsp_id), PW'(2));
    cyc();
    wait_idle("t5");

    // Edge operands: -2^127 * -1 = +2^127.
    set_op(1, {1'b1, {(W-1){1'b0}}}, '1);
    bus.req_valid = 4'b0010;
    wait_rsp("t6");
    chk("t6_rsp_ab", bus.rsp_ab, PW'(1) << (W - 1));
    cyc();
    wait_idle("t6");

    // Randomized traffic, backpressure and spurious done pulses.
    rand_mode = 1'b1;
    rand_spur = 1'b1;
    start     = n_rsp;
    for (int t = 0; t < 6000 && n_rsp < start + 150; t++) cyc();
    n_checks++;
    if (n_rsp < start + 150) begin
      n_errors++;
      $display("FAIL rand_progress: got %0d responses expected %0d", n_rsp - start, 150);
    end
    rand_mode     = 1'b0;
    rand_spur     = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_idle("drain");
    cyc();
    cyc();
    chk("queue_empty", PW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Shares one Booth multiplier (`WIDTH`-bit signed operands, `2*WIDTH`-bit product, variable latency, single load pulse and done indication) between `NREQ` requesters in the MSM datapath. Grants one requester at a time using round-robin order. Latches its operands and sequences the multiplier's load/done handshake. Returns the product, tagged with the requester index, through a single buffered response port.

## Interface
Parameters:
- `WIDTH`, 128, operand width; product is `2*WIDTH`
- `NREQ`, 4, number of requesters, 2..16
- `IDW`, `$clog2(NREQ)`, width of requester index (derived, do not override)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_a`  in  NREQ*WIDTH  signed operand a; requester i occupies `[i*WIDTH +: WIDTH]`
- `req_b`  in  NREQ*WIDTH  signed operand b; same packing as `req_a`
- `req_ready`  out  NREQ  one-hot grant/accept; at most one bit set
- `mul_ld`  out  1  one-cycle load pulse to the multiplier
- `mul_a`, `mul_b`  out  WIDTH  latched operands; held stable from load until done
- `mul_done`  in  1  multiplier result valid
- `mul_ab`  in  2*WIDTH  multiplier product
- `rsp_valid`  out  1  response valid
- `rsp_id`  out  IDW  index of the requester that owns the response
- `rsp_ab`  out  2*WIDTH  signed product
- `rsp_ready`  in  1  response consumer ready
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - Round-robin search starts at `(last+1) mod NREQ`, where `last` is the index of the most recent grant (reset value NREQ-1, so index 0 wins first).
  - The first requester with `req_valid` high gets `req_ready` high in the same cycle (combinational from `req_valid` and `last`).
  - On the accepting edge: latch the requester's a and b into `mul_a`/`mul_b`, latch its index into `rsp_id` and `last`, then go to LOAD.
  - If no request is pending, stay in IDLE and keep `req_ready` at 0.
- LOAD: `mul_ld`=1 for exactly this cycle. `mul_done` is ignored in this cycle (it may be stale from the previous job). Go to WAIT.
- WAIT:
  - `mul_ld`=0.
  - On the first cycle with `mul_done`=1, capture `mul_ab` into `rsp_ab` and go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_id` and `rsp_ab` are held stable.
  - On the edge where `rsp_valid`=1 and `rsp_ready`=1, go to IDLE.
- `req_ready` is 0 in LOAD, WAIT and RESP. No new operands are accepted while a job is outstanding.
- Requests are non-preemptive. A requester may drop `req_valid` at any time before it is granted; it is then simply skipped.
- `mul_done` seen in IDLE or RESP is ignored. It does not affect state or outputs.
- Arithmetic: the product is passed through unmodified. Signed interpretation belongs to the multiplier.
- Reset (any time, including mid-job):
  - State goes to IDLE.
  - `mul_ld`, `req_ready`, `rsp_valid` and `busy` go to 0.
  - `mul_a`, `mul_b`, `rsp_ab` and `rsp_id` go to 0.
  - `last` goes to NREQ-1.
  - The multiplier must share the same reset so that no in-flight done is delivered afterwards.

## Timing
- Cycle 0: accept (`req_valid & req_ready`).
- Cycle 1: LOAD, `mul_ld`=1.
- Cycle 2 onward: WAIT.
- If `mul_done` is seen in cycle k (k≥2), `rsp_valid` rises in cycle k+1.
- Minimum response latency from accept is 3 cycles plus the multiplier's latency.
- After the response handshake edge, IDLE can accept the next request on the following cycle. Minimum spacing between consecutive `mul_ld` pulses is 4 cycles plus the multiplier's latency.
- Back-to-back requesters are served strictly in round-robin order. Any requester held valid is granted within NREQ jobs.
- `rsp_ready` may be held low indefinitely. The FSM stalls in RESP and the multiplier stays idle.

## Test plan
- Single request, requester 2, a=7, b=-3:
  - `req_ready`=4'b0100 in the accept cycle.
  - `mul_ld` pulses once in the next cycle.
  - After `mul_done`: `rsp_valid`=1, `rsp_id`=2, `rsp_ab`=-21.
- All four requesters valid continuously, each with a=i+1, b=10:
  - Grant order is 0,1,2,3,0.
  - Responses come out in that order: 10, 20, 30, 40, 10.
  - No requester is starved.
- Backpressure: hold `rsp_ready`=0 for 20 cycles.
  - `rsp_valid`, `rsp_id` and `rsp_ab` stay stable.
  - `req_ready`=0 and no `mul_ld` pulse occurs.
  - Raise `rsp_ready`: FSM returns to IDLE the next cycle.
- Spurious `mul_done`:
  - Drive `mul_done`=1 in IDLE: no state change.
  - Drive `mul_done`=1 in the LOAD cycle: ignored; the response uses the product presented on the later real done.
- Reset asserted during WAIT (after `mul_ld`, before done):
  - All outputs go to 0 asynchronously.
  - After release, the next grant goes to requester 0 and the job completes with the correct product.
- Edge operands, WIDTH=128: a=-2^127, b=-1.
  - `rsp_ab`=+2^127 in the 256-bit result.
  - Check `mul_a`/`mul_b` are unchanged through WAIT.
